mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Memory access controller directly downstream of the memory-address select mux. Takes the selected 32-bit address plus a load/store request from the control unit and drives the single-port synchronous word memory. Performs sub-word extraction and sign/zero extension on loads. Performs read-modify-write for byte and halfword stores, and flags misaligned accesses.

Parameters:
ADDR_W, 32, address width (memory address output is word-aligned)
DATA_W, 32, data width; fixed 4 byte lanes

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  control unit requests an access
req_ready  out  1  controller idle; request accepted when req_valid && req_ready
addr  in  ADDR_W  byte address from the memory-address mux output
wr  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 illegal
sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend
wdata  in  DATA_W  store data, right-justified
rdata  out  DATA_W  extended load result
done  out  1  one-cycle pulse: access complete
align_exc  out  1  one-cycle pulse: misaligned or illegal access
mem_addr  out  ADDR_W  word address to memory ({addr[31:2],2'b00})
mem_wr  out  1  memory write strobe
mem_wdata  out  DATA_W  full word written to memory
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented with mem_wr=0

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE.
  - rdata=0, done=0, align_exc=0, mem_addr=0, mem_wr=0, mem_wdata=0.
  - req_ready=1 once reset is released.
- req_ready=1 only in IDLE. addr, wr, size, sign_ext and wdata are latched on accept (cycle N); later input changes are ignored until the next accept.
- Byte lanes are little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24. A halfword at offset 2 = bits 31:16.
- States: IDLE, RD, WAIT, WR, RESP.
- Misalignment check at accept:
  - half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Response: align_exc=1 at N+1, no memory access (mem_wr stays 0), done not asserted, return to IDLE (req_ready=1 at N+1).
- Load (any size):
  - N+1 RD: mem_addr driven, mem_wr=0.
  - N+2 WAIT: mem_rdata sampled.
  - N+3 RESP: done=1, rdata = extracted lane, extended per sign_ext. Word loads ignore sign_ext.
  - rdata holds its value until the next load completes; stores and exceptions do not alter it.
  - Latency 3 cycles.
- Word store:
  - N+1 WR: mem_wr=1, mem_wdata=wdata.
  - N+2 RESP: done=1.
- Byte/half store (RMW):
  - N+1 RD, N+2 WAIT: read word captured.
  - N+3 WR: mem_wr=1, mem_wdata = read word with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - N+4 RESP: done=1.
- RESP always returns to IDLE; req_ready=1 in the cycle after done.
- mem_wr is asserted in exactly one cycle per store and never for loads or exceptions. mem_addr is held constant from RD/WR through RESP.
- Reset mid-operation (any state): immediate abort; mem_wr deasserts asynchronously; no partial or late write occurs after release.
- done and align_exc are mutually exclusive and never both 1.

Optional Feature:
MEM_UNALIGNED_EXC_EN
- Defined: misalignment detection and align_exc behave as above.
- Undefined:
  - align_exc is tied to 0.
  - Misaligned half/word accesses are forced aligned: addr[0] is ignored for half, addr[1:0] for word, and the access proceeds normally.
  - size=11 is treated as word.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL;
  - state encoding constants;
  - lane width constant.
- One combinational sub-module, mem_lane_unit, contains both lane paths:
  - load extraction and extension (word, offset, size, sign_ext -> rdata);
  - store merge (old word, wdata, offset, size -> new word).
- The FSM and registers stay in mem_access_ctrl.

Test Plan:
- Memory[0x10]=0x8899AABB; load byte addr 0x13 sign_ext=1 -> done at N+3, rdata=0xFFFFFF88, mem_addr=0x10, mem_wr never 1.
- Same word; load half addr 0x12 sign_ext=0 -> rdata=0x00008899 at N+3; load word 0x10 -> rdata=0x8899AABB.
- Store byte addr 0x11 wdata=0x123456CC -> one mem_wr pulse at N+3 with mem_wdata=0x8899CCBB; done at N+4; subsequent load word 0x10 returns 0x8899CCBB.
- Store word addr 0x20 wdata=0xDEADBEEF -> mem_wr at N+1, done at N+2; with macro defined, load word addr 0x12 -> align_exc at N+1, no done, no memory access, req_ready=1 at N+1.
- Store half addr 0x16 asserting reset_n=0 during WAIT -> mem_wr never asserted, all outputs 0, memory word unchanged; after release a new request is accepted normally.
- Macro undefined: load word addr 0x13 -> treated as 0x10, rdata=0x8899AABB at N+3, align_exc stays 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access controller: access sizes, FSM states,
// lane geometry and the small alignment helpers used at request accept.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = LANE_W * NUM_LANES;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  // Lane offset actually used by the access: low bits below the access size are dropped.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: align_offset = off;
      SZ_HALF: align_offset = {off[1], 1'b0};
      default: align_offset = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane datapath: load extraction with sign/zero extension,
// and store merge of a byte/halfword into an existing little-endian word.
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  output logic [WORD_W-1:0] o_load,
  output logic [WORD_W-1:0] o_store
);

  logic [LANE_W-1:0]   w_byte;
  logic [2*LANE_W-1:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: LANE_W];
  assign w_half = i_off[1] ? i_word[WORD_W-1:2*LANE_W] : i_word[2*LANE_W-1:0];

  // Load path: word loads pass through untouched, sign_ext only matters for sub-words.
  always_comb begin
    o_load = '0;
    case (i_size)
      SZ_BYTE: o_load = {{(WORD_W-LANE_W){i_sign_ext & w_byte[LANE_W-1]}}, w_byte};
      SZ_HALF: o_load = {{(WORD_W-2*LANE_W){i_sign_ext & w_half[2*LANE_W-1]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  // Store path: replace only the addressed lane(s) of the word read back from memory.
  always_comb begin
    o_store = i_word;
    case (i_size)
      SZ_BYTE: o_store[{i_off, 3'b000} +: LANE_W] = i_wdata[LANE_W-1:0];
      SZ_HALF: begin
        if (i_off[1]) begin
          o_store[WORD_W-1:2*LANE_W] = i_wdata[2*LANE_W-1:0];
        end else begin
          o_store[2*LANE_W-1:0] = i_wdata[2*LANE_W-1:0];
        end
      end
      default: o_store = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a single-port synchronous word memory.
// Define MEM_UNALIGNED_EXC_EN to trap misaligned/illegal accesses; otherwise they are forced aligned.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              align_exc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t r_state;
  state_t w_next_state;

  logic              r_ready;
  logic              r_wr;
  logic              r_sign;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_done;
  logic              r_exc;
  logic              r_mem_wr;

  logic              w_accept;
  logic              w_go;
  logic              w_misalign;
  logic [1:0]        w_size_eff;
  logic [1:0]        w_off_eff;
  logic [DATA_W-1:0] w_load_word;
  logic [DATA_W-1:0] w_store_word;

`ifdef MEM_UNALIGNED_EXC_EN
  assign w_size_eff = size;
  assign w_misalign = is_misaligned(size, addr[1:0]);
`else
  assign w_size_eff = (size == SZ_ILL) ? SZ_WORD : size;
  assign w_misalign = 1'b0;
`endif

  assign w_off_eff = align_offset(w_size_eff, addr[1:0]);
  assign w_accept  = req_valid && r_ready;
  assign w_go      = w_accept && !w_misalign;

  mem_lane_unit u_lane (
    .i_word     (mem_rdata),
    .i_wdata    (r_wdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_sign_ext (r_sign),
    .o_load     (w_load_word),
    .o_store    (w_store_word)
  );

  // Word stores skip the read; every other access reads the word first.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          if (wr && (w_size_eff == SZ_WORD)) begin
            w_next_state = ST_WR;
          end else begin
            w_next_state = ST_RD;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD:   w_next_state = ST_WAIT;
      ST_WAIT: w_next_state = r_wr ? ST_WR : ST_RESP;
      ST_WR:   w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request fields are captured once at accept and held for the whole access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr       <= 1'b0;
      r_sign     <= 1'b0;
      r_size     <= SZ_BYTE;
      r_off      <= 2'b00;
      r_wdata    <= '0;
      r_mem_addr <= '0;
    end else if (w_go) begin
      r_wr       <= wr;
      r_sign     <= sign_ext;
      r_size     <= w_size_eff;
      r_off      <= w_off_eff;
      r_wdata    <= wdata;
      r_mem_addr <= {addr[ADDR_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_exc       <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_ready  <= (w_next_state == ST_IDLE);
      r_done   <= (w_next_state == ST_RESP);
      r_exc    <= w_accept && w_misalign;
      r_mem_wr <= (w_next_state == ST_WR);
      if (w_next_state == ST_WR) begin
        r_mem_wdata <= (r_state == ST_WAIT) ? w_store_word : wdata;
      end
      if ((r_state == ST_WAIT) && !r_wr) begin
        r_rdata <= w_load_word;
      end
    end
  end

  assign req_ready = r_ready;
  assign rdata     = r_rdata;
  assign done      = r_done;
  assign align_exc = r_exc;
  assign mem_addr  = r_mem_addr;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level model predicts per-cycle
// handshake/memory activity and load results; literal checks pin the model.
module tb_mem_access_ctrl;

  localparam int K_NONE = 0;
  localparam int K_EXC  = 1;
  localparam int K_LOAD = 2;
  localparam int K_STW  = 3;
  localparam int K_STS  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        align_exc;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;
  logic tb_init = 1'b1;

  int          t_kind = K_NONE;
  int          t_acc  = 0;
  int          t_len  = 0;
  int          t_wr_d = 0;
  logic [31:0] t_maddr = 32'h0;
  logic [31:0] t_wword = 32'h0;
  logic [31:0] t_rval  = 32'h0;
  logic [31:0] exp_rdata_hold = 32'h0;

  logic [31:0] env_mem [0:63];
  logic [31:0] ref_mem [0:63];

  mem_access_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr      (addr),
    .wr        (wr),
    .size      (size),
    .sign_ext  (sign_ext),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .align_exc (align_exc),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seed(input int i);
    return (i == 4) ? 32'h8899AABB : 32'(32'h01010101 * i);
  endfunction

  // Synchronous single-port word memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= seed(i);
    end else begin
      if (mem_wr) env_mem[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= env_mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Per-cycle comparison of DUT outputs against the active transaction's predicted timeline.
  always @(negedge clk) begin : cmp
    int d;
    bit act;
    bit e_done, e_exc, e_wr, e_ready;
    if (!reset_n) begin
      exp_rdata_hold = 32'h0;
    end else if (cmp_en) begin
      d       = cyc - t_acc + 1;
      act     = (t_kind != K_NONE) && (d >= 1) && (d <= t_len);
      e_done  = act && (d == t_len) && (t_kind != K_EXC);
      e_exc   = act && (t_kind == K_EXC) && (d == 1);
      e_wr    = act && (t_wr_d != 0) && (d == t_wr_d);
      e_ready = !act || (t_kind == K_EXC);
      if (e_done && t_kind == K_LOAD) exp_rdata_hold = t_rval;
      chk1("done", done, e_done);
      chk1("align_exc", align_exc, e_exc);
      chk1("mem_wr", mem_wr, e_wr);
      chk1("req_ready", req_ready, e_ready);
      chk1("done_exc_excl", done & align_exc, 1'b0);
      chk("rdata", rdata, exp_rdata_hold);
      if (act && t_kind != K_EXC) chk("mem_addr", mem_addr, t_maddr);
      if (e_wr) chk("mem_wdata", mem_wdata, t_wword);
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd, input int abort_d);
    int to;
    int esz;
    int off;
    int idx;
    bit mis;
    logic [31:0] ea, old, v, mask;
    to = 0;
    while (req_ready !== 1'b1 && to < 20) begin
      @(negedge clk); #1;
      to++;
    end
    chk1("ready_wait", req_ready, 1'b1);
    esz = int'(sz);
    ea  = a;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifndef MEM_UNALIGNED_EXC_EN
    mis = 1'b0;
    if (esz == 3) esz = 2;
    if (esz == 1) ea = a & ~32'h1;
    if (esz == 2) ea = a & ~32'h3;
`endif
    off     = int'(ea % 4);
    idx     = int'((ea / 4) % 64);
    old     = ref_mem[idx];
    t_maddr = a & ~32'h3;
    t_wword = 32'h0;
    t_rval  = 32'h0;
    if (mis) begin
      t_kind = K_EXC; t_len = 1; t_wr_d = 0;
    end else if (!w) begin
      t_kind = K_LOAD; t_len = 3; t_wr_d = 0;
      if (esz == 0) begin
        v = (old >> (8 * off)) % 256;
        if (sx && v >= 128) v = v + 32'hFFFFFF00;
      end else if (esz == 1) begin
        v = (old >> (8 * off)) % 65536;
        if (sx && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
        v = old;
      end
      t_rval = v;
    end else if (esz == 2) begin
      t_kind = K_STW; t_len = 2; t_wr_d = 1;
      t_wword = wd;
    end else begin
      t_kind = K_STS; t_len = 4; t_wr_d = 3;
      mask = (esz == 0) ? 32'hFF : 32'hFFFF;
      t_wword = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    end
    if (abort_d == 0 && (t_kind == K_STW || t_kind == K_STS)) ref_mem[idx] = t_wword;
    addr = a; wr = w; size = sz; sign_ext = sx; wdata = wd;
    req_valid = 1'b1;
    t_acc = cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr = $urandom; wr = ~w; size = 2'($urandom); sign_ext = ~sx; wdata = $urandom;
    if (abort_d > 0) begin
      repeat (abort_d) @(negedge clk);
      #1;
      reset_n = 1'b0;
      t_kind  = K_NONE;
      #1;
      chk1("abort_done", done, 1'b0);
      chk1("abort_exc", align_exc, 1'b0);
      chk1("abort_mem_wr_now", mem_wr, 1'b0);
      chk("abort_mem_wdata", mem_wdata, 32'h0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      chk("abort_rdata", rdata, 32'h0);
      repeat (2) begin
        @(negedge clk);
        chk1("abort_mem_wr", mem_wr, 1'b0);
      end
      #1 reset_n = 1'b1;
    end else begin
      repeat (t_len) @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
    reset_n = 1'b0; req_valid = 1'b0; addr = 32'h0; wr = 1'b0;
    size = 2'b00; sign_ext = 1'b0; wdata = 32'h0;
    @(posedge clk); #1;
    tb_init = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_exc", align_exc, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    chk1("rst_ready", req_ready, 1'b1);
    cmp_en = 1'b1;

    do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0);
    chk("lit_lb13", rdata, 32'hFFFFFF88);
    do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0);
    chk("lit_lh12", rdata, 32'h00008899);
    do_req(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 0);
    chk("lit_lw10", rdata, 32'h8899AABB);
    do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h123456CC, 0);
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);
    chk("lit_lw10_rmw", rdata, 32'h8899CCBB);
    do_req(1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 0);
    chk("lit_lb10", rdata, 32'h000000BB);
    do_req(1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 0);
    chk("lit_lh10_sx", rdata, 32'hFFFFCCBB);
    do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0);
    chk("lit_lw20", rdata, 32'hDEADBEEF);
    do_req(1'b1, 32'h22, 2'b01, 1'b0, 32'hABCD7777, 0);
    do_req(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 0);
    chk("lit_lh22", rdata, 32'h00007777);
    do_req(1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 0);
    chk("lit_lb21", rdata, 32'hFFFFFFBE);

    do_req(1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h13, 2'b10, 1'b0, 32'h0, 0);
`ifndef MEM_UNALIGNED_EXC_EN
    chk("lit_lw13_forced", rdata, 32'h8899CCBB);
`else
    chk("lit_exc_keeps_rdata", rdata, 32'hFFFFFFBE);
`endif
    do_req(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 0);
    do_req(1'b0, 32'h11, 2'b01, 1'b1, 32'h0, 0);
    do_req(1'b1, 32'h21, 2'b10, 1'b0, 32'h55555555, 0);
    do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0);
`ifndef MEM_UNALIGNED_EXC_EN
    chk("lit_sw21_forced", rdata, 32'h55555555);
`else
    chk("lit_sw21_trapped", rdata, 32'h7777BEEF);
`endif

    do_req(1'b1, 32'h16, 2'b01, 1'b0, 32'h00004444, 2);
    chk("lit_abort_mem", env_mem[5], 32'h05050505);
    do_req(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 0);
    chk("lit_lw14_after_abort", rdata, 32'h05050505);
    do_req(1'b1, 32'h16, 2'b01, 1'b0, 32'h00004444, 0);
    do_req(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 0);
    chk("lit_lw14_sh", rdata, 32'h44440505);

    @(negedge clk); #1;
    chk("lit_mem10", env_mem[4], 32'h8899CCBB);
    chk("mem20_vs_model", env_mem[8], ref_mem[8]);
    chk("mem14_vs_model", env_mem[5], ref_mem[5]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
